// File: rtl/freq_stepper_drive.sv
// Drive-frequency owner for the resonant tracker: steps freq on request, settles, and
// generates dead-time half-bridge gates from a phase accumulator. Optional macro: FINE_STEP_EN.
module freq_stepper_drive #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned TUNE_MULT  = 86,
  parameter int unsigned FREQ_START = 40000,
  parameter int unsigned FREQ_MIN   = 20000,
  parameter int unsigned FREQ_MAX   = 100000,
  parameter int unsigned STEP       = 500,
  parameter int unsigned FINE_STEP  = 100,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned DEAD_CYC   = 10
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               run,
  input  logic               freq_ready,
  input  logic               freq_set_up_down,
  input  logic               freq_opt,
  output logic [19:0]        freq,
  output logic [PHASE_W-1:0] inc_live,
  output logic               data_start,
  output logic               gate_h,
  output logic               gate_l,
  output logic               at_limit,
  output logic               busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  localparam int unsigned CNT_W  = $clog2(SETTLE_CYC + 2);
  localparam int unsigned DEAD_W = $clog2(DEAD_CYC + 2);

  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [DEAD_W-1:0]  DEAD_LD   = DEAD_W'(DEAD_CYC);
  localparam logic [20:0]        FMIN_W    = 21'(FREQ_MIN);
  localparam logic [20:0]        FMAX_W    = 21'(FREQ_MAX);
  localparam logic [20:0]        STEP_W    = 21'(STEP);
  localparam logic [19:0]        FSTART_W  = 20'(FREQ_START);
  localparam logic [PHASE_W-1:0] INC_START = PHASE_W'(FREQ_START * TUNE_MULT);

  if (CLK_HZ == 0 || FINE_STEP == 0 || FREQ_MIN > FREQ_MAX) begin : g_bad_params
    $error("freq_stepper_drive: inconsistent parameters");
  end

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [19:0]         freq_q, freq_d;
  logic                at_limit_q, at_limit_d;
  logic                data_start_q, data_start_d;
  logic [PHASE_W-1:0]  acc_q, acc_d;
  logic [PHASE_W-1:0]  inc_q, inc_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                sq_prev_q, sq_prev_d;
  logic                gate_h_q, gate_h_d;
  logic                gate_l_q, gate_l_d;
  logic                busy_q, busy_d;

  logic                req_s;
  logic [20:0]         step_s, freq_ext_s, up_sum_s, next_s;
  logic [PHASE_W:0]    sum_s;
  logic [PHASE_W-1:0]  inc_calc_s;
  logic                active_s, sq_s, drive_s;

  // Clamped next frequency; 21-bit arithmetic so neither direction can wrap.
  always_comb begin
    freq_ext_s = {1'b0, freq_q};
`ifdef FINE_STEP_EN
    req_s      = freq_ready;
    step_s     = freq_opt ? 21'(FINE_STEP) : STEP_W;
`else
    req_s      = freq_ready & ~freq_opt;
    step_s     = STEP_W;
`endif
    up_sum_s   = freq_ext_s + step_s;
    if (freq_set_up_down) begin
      next_s = (up_sum_s > FMAX_W) ? FMAX_W : up_sum_s;
    end else if (freq_ext_s < FMIN_W + step_s) begin
      next_s = FMIN_W;
    end else begin
      next_s = freq_ext_s - step_s;
    end
  end

  assign sum_s      = {1'b0, acc_q} + {1'b0, inc_q};
  assign inc_calc_s = PHASE_W'(32'(freq_q) * 32'(TUNE_MULT));
  assign sq_s       = acc_q[PHASE_W-1];
  assign active_s   = run && (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freq_d       = freq_q;
    at_limit_d   = at_limit_q;
    data_start_d = 1'b0;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end
        S_SETTLE: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            data_start_d = 1'b1;
            state_d      = S_RUN;
          end
        end
        S_RUN: begin
          // A request landing on the data_start cycle belongs to the old measurement.
          if (req_s && !data_start_q) begin
            freq_d     = next_s[19:0];
            at_limit_d = (next_s == FMIN_W) || (next_s == FMAX_W);
            cnt_d      = SETTLE_LD;
            state_d    = S_SETTLE;
          end else begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_SETTLE);
  end

  // New increments are only taken at a wrap so every period is whole.
  always_comb begin
    acc_d     = {PHASE_W{1'b0}};
    inc_d     = inc_q;
    dead_d    = {DEAD_W{1'b0}};
    sq_prev_d = 1'b0;
    if (active_s) begin
      acc_d     = sum_s[PHASE_W-1:0];
      sq_prev_d = sq_s;
      if (sum_s[PHASE_W]) begin
        inc_d = inc_calc_s;
      end else begin
        inc_d = inc_q;
      end
      if (sq_s != sq_prev_q) begin
        dead_d = DEAD_LD;
      end else if (dead_q != {DEAD_W{1'b0}}) begin
        dead_d = dead_q - DEAD_W'(1);
      end else begin
        dead_d = {DEAD_W{1'b0}};
      end
    end else begin
      acc_d = {PHASE_W{1'b0}};
    end
    drive_s  = active_s && (dead_d == {DEAD_W{1'b0}});
    gate_h_d = drive_s & sq_s;
    gate_l_d = drive_s & ~sq_s;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      freq_q       <= FSTART_W;
      at_limit_q   <= 1'b0;
      data_start_q <= 1'b0;
      acc_q        <= {PHASE_W{1'b0}};
      inc_q        <= INC_START;
      dead_q       <= {DEAD_W{1'b0}};
      sq_prev_q    <= 1'b0;
      gate_h_q     <= 1'b0;
      gate_l_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      freq_q       <= freq_d;
      at_limit_q   <= at_limit_d;
      data_start_q <= data_start_d;
      acc_q        <= acc_d;
      inc_q        <= inc_d;
      dead_q       <= dead_d;
      sq_prev_q    <= sq_prev_d;
      gate_h_q     <= gate_h_d;
      gate_l_q     <= gate_l_d;
      busy_q       <= busy_d;
    end
  end

  assign freq       = freq_q;
  assign inc_live   = inc_q;
  assign data_start = data_start_q;
  assign gate_h     = gate_h_q;
  assign gate_l     = gate_l_q;
  assign at_limit   = at_limit_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_freq_stepper_drive.sv
// Self-checking bench for freq_stepper_drive: a frequency/limit model plus period and
// dead-time measurements; honours FINE_STEP_EN the same way the design does.
module tb_freq_stepper_drive;
  localparam int PW      = 32;
  localparam int TM      = 86;
  localparam int F_START = 40000;
  localparam int F_MIN   = 20000;
  localparam int F_MAX   = 100000;
  localparam int STEP_HZ = 500;
  localparam int FINE_HZ = 100;
  localparam int S       = 100;
  localparam int DEAD    = 10;

  logic clk = 1'b0;
  logic nrst, run, freq_ready, freq_set_up_down, freq_opt;
  logic [19:0]   freq;
  logic [PW-1:0] inc_live;
  logic data_start, gate_h, gate_l, at_limit, busy;

  int checks = 0;
  int failures = 0;
  int exp_f;
  bit exp_lim;

  freq_stepper_drive #(
    .PHASE_W(PW), .TUNE_MULT(TM), .FREQ_START(F_START), .FREQ_MIN(F_MIN), .FREQ_MAX(F_MAX),
    .STEP(STEP_HZ), .FINE_STEP(FINE_HZ), .SETTLE_CYC(S), .DEAD_CYC(DEAD)
  ) dut (
    .clk(clk), .nrst(nrst), .run(run), .freq_ready(freq_ready),
    .freq_set_up_down(freq_set_up_down), .freq_opt(freq_opt), .freq(freq),
    .inc_live(inc_live), .data_start(data_start), .gate_h(gate_h), .gate_l(gate_l),
    .at_limit(at_limit), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (gate_h === 1'b1 && gate_l === 1'b1) begin
      failures++;
      $display("FAIL gate_overlap t=%0t: gate_h=%b gate_l=%b, required never both 1", $time, gate_h, gate_l);
    end
  end

  function automatic bit model_accepts(bit opt);
`ifdef FINE_STEP_EN
    return 1'b1;
`else
    return !opt;
`endif
  endfunction

  function automatic int model_next(int f, bit up, bit opt);
    int st;
    st = STEP_HZ;
`ifdef FINE_STEP_EN
    if (opt) st = FINE_HZ;
`endif
    if (!model_accepts(opt)) return f;
    if (up) return (f + st > F_MAX) ? F_MAX : f + st;
    return (f - st < F_MIN) ? F_MIN : f - st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input bit up, input bit opt);
    freq_ready = 1'b1; freq_set_up_down = up; freq_opt = opt;
    tick();
    freq_ready = 1'b0; freq_opt = 1'b0;
  endtask

  task automatic wait_ds(input int limit, output int cyc, output int nbusy);
    cyc = -1; nbusy = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (data_start === 1'b1) begin
        cyc = i;
        break;
      end
      if (busy === 1'b1) nbusy++;
    end
  endtask

  task automatic measure(output int per, output int gap);
    int first, low;
    logic ph;
    per = -1; gap = -1; first = -1; low = 0; ph = gate_h;
    for (int i = 0; i < 12000; i++) begin
      tick();
      if (gate_h === 1'b1 && ph !== 1'b1) begin
        if (first < 0) begin
          first = i; gap = low;
        end else begin
          per = i - first;
          break;
        end
      end
      low = (gate_h === 1'b0 && gate_l === 1'b0) ? low + 1 : 0;
      ph = gate_h;
    end
  endtask

  // Applies one request to the model; at_limit only moves when the request is accepted.
  task automatic model_apply(input bit up, input bit opt);
    if (model_accepts(opt)) begin
      exp_f   = model_next(exp_f, up, opt);
      exp_lim = (exp_f == F_MIN) || (exp_f == F_MAX);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; run = 1'b0; freq_ready = 1'b0; freq_set_up_down = 1'b0; freq_opt = 1'b0;
    repeat (3) tick();
    checks++;
    if (freq !== 20'(F_START)) begin failures++; $display("FAIL reset_freq: got %0d expected %0d", freq, F_START); end
    checks++;
    if (inc_live !== PW'(F_START * TM)) begin failures++; $display("FAIL reset_inc: got %0d expected %0d", inc_live, F_START * TM); end
    checks++;
    if ({data_start, gate_h, gate_l, at_limit, busy} !== 5'b00000) begin
      failures++; $display("FAIL reset_outputs: ds,gh,gl,lim,busy got %b expected 00000", {data_start, gate_h, gate_l, at_limit, busy});
    end
    nrst = 1'b1;
    exp_f = F_START; exp_lim = 1'b0;
    tick();
  endtask

  task automatic test_startup();
    int cyc, nb, per, gap;
    real p;
    run = 1'b1;
    wait_ds(S + 50, cyc, nb);
    checks++;
    if (cyc < S + 1 || cyc > S + 2) begin failures++; $display("FAIL start_settle: data_start at %0d expected %0d..%0d", cyc, S + 1, S + 2); end
    checks++;
    if (nb != cyc - 1 || busy !== 1'b0) begin failures++; $display("FAIL start_busy: busy cycles %0d busy_at_ds %b expected %0d and 0", nb, busy, cyc - 1); end
    tick();
    checks++;
    if (data_start !== 1'b0) begin failures++; $display("FAIL start_pulse_width: data_start got %b expected 0", data_start); end
    measure(per, gap);
    p = 4294967296.0 / (real'(exp_f) * TM);
    checks++;
    if (per < 0 || $itor(per) - p > 1.5 || p - $itor(per) > 1.5) begin failures++; $display("FAIL start_period: got %0d expected %0.1f", per, p); end
    checks++;
    if (gap != DEAD) begin failures++; $display("FAIL start_deadtime: got %0d expected %0d", gap, DEAD); end
  endtask

  task automatic test_step_apply();
    int ds_at, inc_at, per, gap;
    logic ph;
    logic [PW-1:0] prev_inc;
    bit chk_next;
    real p;
    pulse_req(1'b1, 1'b0);
    model_apply(1'b1, 1'b0);
    checks++;
    if (freq !== 20'(exp_f) || busy !== 1'b1 || at_limit !== exp_lim) begin
      failures++; $display("FAIL step_up: freq %0d busy %b lim %b expected %0d 1 %b", freq, busy, at_limit, exp_f, exp_lim);
    end
    ds_at = -1; inc_at = -1; chk_next = 1'b0; ph = gate_h; prev_inc = inc_live;
    for (int i = 1; i <= 4000 && !(ds_at >= 0 && inc_at >= 0 && !chk_next); i++) begin
      tick();
      if (chk_next) begin
        chk_next = 1'b0;
        checks++;
        if (gate_h !== 1'b0) begin failures++; $display("FAIL inc_at_wrap: gate_h after increment change got %b expected 0", gate_h); end
      end
      if (data_start === 1'b1 && ds_at < 0) ds_at = i;
      if (inc_live !== prev_inc && inc_at < 0) begin
        inc_at = i;
        chk_next = 1'b1;
        checks++;
        if (ph !== 1'b1 || inc_live !== PW'(exp_f * TM)) begin
          failures++; $display("FAIL inc_update: inc %0d gate_h_before %b expected %0d and 1", inc_live, ph, exp_f * TM);
        end
      end
      ph = gate_h; prev_inc = inc_live;
    end
    checks++;
    if (inc_at < 0) begin failures++; $display("FAIL inc_never_loaded: got none expected %0d", exp_f * TM); end
    checks++;
    if (ds_at < S || ds_at > S + 1) begin failures++; $display("FAIL step_settle: data_start at %0d expected %0d..%0d", ds_at, S, S + 1); end
    measure(per, gap);
    p = 4294967296.0 / (real'(exp_f) * TM);
    checks++;
    if (per < 0 || $itor(per) - p > 1.5 || p - $itor(per) > 1.5) begin failures++; $display("FAIL step_period: got %0d expected %0.1f", per, p); end
    checks++;
    if (gap != DEAD) begin failures++; $display("FAIL step_deadtime: got %0d expected %0d", gap, DEAD); end
  endtask

  task automatic test_opt();
    int cyc, nb;
    pulse_req(1'b1, 1'b1);
    model_apply(1'b1, 1'b1);
    checks++;
    if (freq !== 20'(exp_f)) begin failures++; $display("FAIL opt_freq: got %0d expected %0d", freq, exp_f); end
`ifdef FINE_STEP_EN
    wait_ds(S + 20, cyc, nb);
    checks++;
    if (cyc < S || cyc > S + 1) begin failures++; $display("FAIL opt_fine_settle: data_start at %0d expected %0d..%0d", cyc, S, S + 1); end
    tick();
`else
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL opt_frozen_busy: got %b expected 0", busy); end
    wait_ds(S + 20, cyc, nb);
    checks++;
    if (cyc != -1) begin failures++; $display("FAIL opt_frozen_ds: data_start at %0d expected none", cyc); end
`endif
  endtask

  task automatic test_coincide();
    int cyc, nb;
    pulse_req(1'b0, 1'b0);
    model_apply(1'b0, 1'b0);
    wait_ds(S + 20, cyc, nb);
    freq_ready = 1'b1; freq_set_up_down = 1'b1;
    tick();
    freq_ready = 1'b0;
    checks++;
    if (freq !== 20'(exp_f) || busy !== 1'b0) begin
      failures++; $display("FAIL coincide_ignored: freq %0d busy %b expected %0d 0", freq, busy, exp_f);
    end
    wait_ds(S + 20, cyc, nb);
    checks++;
    if (cyc != -1) begin failures++; $display("FAIL coincide_no_ds: data_start at %0d expected none", cyc); end
  endtask

  task automatic test_limits();
    int cyc, nb;
    for (int k = 0; k < 2; k++) begin
      while (exp_f != (k == 0 ? F_MAX : F_MIN)) begin
        pulse_req(k == 0, 1'b0);
        model_apply(k == 0, 1'b0);
        checks++;
        if (freq !== 20'(exp_f) || at_limit !== exp_lim) begin
          failures++; $display("FAIL walk_%0d: freq %0d lim %b expected %0d %b", k, freq, at_limit, exp_f, exp_lim);
        end
        wait_ds(S + 20, cyc, nb);
        tick();
      end
      pulse_req(k == 0, 1'b0);
      checks++;
      if (freq !== 20'(exp_f) || at_limit !== 1'b1 || busy !== 1'b1) begin
        failures++; $display("FAIL clamp_%0d: freq %0d lim %b busy %b expected %0d 1 1", k, freq, at_limit, busy, exp_f);
      end
      wait_ds(S + 20, cyc, nb);
      checks++;
      if (cyc < S || cyc > S + 1) begin failures++; $display("FAIL clamp_ds_%0d: data_start at %0d expected %0d..%0d", k, cyc, S, S + 1); end
      tick();
    end
    pulse_req(1'b1, 1'b0);
    model_apply(1'b1, 1'b0);
    checks++;
    if (freq !== 20'(F_MIN + STEP_HZ) || at_limit !== 1'b0) begin
      failures++; $display("FAIL leave_min: freq %0d lim %b expected %0d 0", freq, at_limit, F_MIN + STEP_HZ);
    end
    wait_ds(S + 20, cyc, nb);
    tick();
  endtask

  task automatic test_run_toggle();
    int cyc, nb;
    pulse_req(1'b1, 1'b0);
    model_apply(1'b1, 1'b0);
    repeat (20) tick();
    run = 1'b0;
    tick();
    checks++;
    if ({gate_h, gate_l, busy} !== 3'b000 || freq !== 20'(exp_f) || at_limit !== exp_lim) begin
      failures++; $display("FAIL run_off: gh,gl,busy %b freq %0d lim %b expected 000 %0d %b", {gate_h, gate_l, busy}, freq, at_limit, exp_f, exp_lim);
    end
    wait_ds(S + 20, cyc, nb);
    checks++;
    if (cyc != -1) begin failures++; $display("FAIL run_off_ds: data_start at %0d expected none", cyc); end
    run = 1'b1;
    wait_ds(S + 50, cyc, nb);
    checks++;
    if (cyc < S + 1 || cyc > S + 2 || freq !== 20'(exp_f)) begin
      failures++; $display("FAIL run_on_settle: data_start at %0d freq %0d expected %0d..%0d %0d", cyc, freq, S + 1, S + 2, exp_f);
    end
    tick();
  endtask

  task automatic test_reset_mid_settle();
    int cyc, nb;
    pulse_req(1'b0, 1'b0);
    repeat (10) tick();
    nrst = 1'b0; run = 1'b0;
    tick();
    nrst = 1'b1;
    exp_f = F_START; exp_lim = 1'b0;
    checks++;
    if (freq !== 20'(F_START) || inc_live !== PW'(F_START * TM) || {data_start, gate_h, gate_l, at_limit, busy} !== 5'b00000) begin
      failures++; $display("FAIL mid_reset: freq %0d inc %0d flags %b expected %0d %0d 00000", freq, inc_live, {data_start, gate_h, gate_l, at_limit, busy}, F_START, F_START * TM);
    end
    wait_ds(S + 20, cyc, nb);
    checks++;
    if (cyc != -1) begin failures++; $display("FAIL mid_reset_ds: data_start at %0d expected none", cyc); end
    run = 1'b1;
    wait_ds(S + 50, cyc, nb);
    tick();
  endtask

  task automatic test_random();
    int cyc, nb, per, gap;
    bit up, opt, acc;
    real p;
    for (int n = 0; n < 30; n++) begin
      up  = 1'($urandom_range(0, 1));
      opt = ($urandom_range(0, 3) == 0);
      acc = model_accepts(opt);
      pulse_req(up, opt);
      model_apply(up, opt);
      checks++;
      if (freq !== 20'(exp_f) || at_limit !== exp_lim || busy !== acc) begin
        failures++; $display("FAIL rand_%0d: freq %0d lim %b busy %b expected %0d %b %b", n, freq, at_limit, busy, exp_f, exp_lim, acc);
      end
      if (acc) begin
        wait_ds(S + 20, cyc, nb);
        checks++;
        if (cyc < S || cyc > S + 1) begin failures++; $display("FAIL rand_ds_%0d: data_start at %0d expected %0d..%0d", n, cyc, S, S + 1); end
      end
      tick();
    end
    measure(per, gap);
    measure(per, gap);
    p = 4294967296.0 / (real'(exp_f) * TM);
    checks++;
    if (per < 0 || $itor(per) - p > 1.5 || p - $itor(per) > 1.5 || gap != DEAD) begin
      failures++; $display("FAIL rand_period: period %0d gap %0d expected %0.1f %0d", per, gap, p, DEAD);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_step_apply();
    test_opt();
    test_coincide();
    test_limits();
    test_run_toggle();
    test_reset_mid_settle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
